sram_client_arbiter: RTL and testbench

SRAM_CLIENT_ARBITER -- requirements
Module: sram_client_arbiter

---
 rtl/sram_arb_pkg.sv | 35 +++
 rtl/arb_timeout_counter.sv | 28 ++
 rtl/sram_client_arbiter.sv | 172 +++++++++++++++++
 tb/tb_sram_client_arbiter.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_arb_pkg.sv
// Shared types for the SRAM client arbiter: client IDs, FSM states, VGA phase codes
// and the latched Wishbone request bundle.
package sram_arb_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int SEL_W  = 4;

  typedef enum logic [1:0] {
    CLI_CPU  = 2'd0,
    CLI_VGA  = 2'd1,
    CLI_UART = 2'd2,
    CLI_NONE = 2'd3
  } client_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACTIVE  = 2'd1,
    ST_RELEASE = 2'd2
  } arb_state_e;

  typedef enum logic [1:0] {
    VGA_INACTIVE   = 2'd0,
    VGA_PRE_ACTIVE = 2'd1,
    VGA_ACTIVE     = 2'd2
  } vga_state_e;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [SEL_W-1:0]  sel;
  } wb_req_t;

endpackage

// File: rtl/arb_timeout_counter.sv
// Counts cycles of an open bus transaction; expired is high in the last allowed cycle.
module arb_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic nrst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst)
      cnt <= '0;
    else if (clr)
      cnt <= '0;
    else if (en && !expired)
      cnt <= cnt + CNT_W'(1);
  end

  assign expired = en && (cnt == LAST);

endmodule

// File: rtl/sram_client_arbiter.sv
// Arbitrates CPU, UART and VGA onto a single Wishbone master port; VGA has absolute
// priority, CPU/UART alternate, and a stalled slave is aborted after TIMEOUT_CYCLES.
module sram_client_arbiter
  import sram_arb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter bit RR_INIT        = 1'b0
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic [3:0]  cpu_sel,
  output logic [31:0] cpu_rdata,
  output logic        cpu_ack,
  input  logic        uart_req,
  input  logic        uart_we,
  input  logic [31:0] uart_addr,
  input  logic [31:0] uart_wdata,
  input  logic [3:0]  uart_sel,
  output logic [31:0] uart_rdata,
  output logic        uart_ack,
  input  logic        vga_req,
  input  logic [31:0] vga_addr,
  input  logic [3:0]  vga_sel,
  input  logic [1:0]  vga_state,
  output logic [31:0] vga_rdata,
  output logic        vga_busy,
  output logic        wb_cyc,
  output logic        wb_stb,
  output logic        wb_we,
  output logic [31:0] wb_adr,
  output logic [31:0] wb_dat_o,
  output logic [3:0]  wb_sel,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack,
  output logic [1:0]  current_client,
  output logic        bus_err
);

  arb_state_e state, next_state;
  client_e    grant_cli, lat_cli;
  wb_req_t    grant_req, lat_req;
  logic       grant_vld;
  logic       rr_ptr;  // 0: CPU served last, 1: UART served last
  logic       vga_block;
  logic       expired;
  logic       txn_end, txn_to;

  assign vga_block = (vga_state == VGA_PRE_ACTIVE) || (vga_state == VGA_ACTIVE);
  assign txn_end   = (state == ST_ACTIVE) && (wb_ack || expired);
  assign txn_to    = (state == ST_ACTIVE) && expired && !wb_ack;

  arb_timeout_counter #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .clk     (clk),
    .nrst    (nrst),
    .clr     (state != ST_ACTIVE),
    .en      (state == ST_ACTIVE),
    .expired (expired)
  );

  always_comb begin
    grant_cli = CLI_NONE;
    if (vga_req)
      grant_cli = CLI_VGA;
    else if (!vga_block && cpu_req && uart_req)
      grant_cli = rr_ptr ? CLI_CPU : CLI_UART;
    else if (!vga_block && cpu_req)
      grant_cli = CLI_CPU;
    else if (!vga_block && uart_req)
      grant_cli = CLI_UART;
  end

  assign grant_vld = (grant_cli != CLI_NONE);

  always_comb begin
    grant_req = '0;
    case (grant_cli)
      CLI_CPU:  grant_req = {cpu_we, cpu_addr, cpu_wdata, cpu_sel};
      CLI_UART: grant_req = {uart_we, uart_addr, uart_wdata, uart_sel};
      CLI_VGA:  grant_req = {1'b0, vga_addr, 32'd0, vga_sel};
      default:  grant_req = '0;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst)
      state <= ST_IDLE;
    else
      state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:    if (grant_vld) next_state = ST_ACTIVE;
      ST_ACTIVE:  if (txn_end) next_state = ST_RELEASE;
      ST_RELEASE: next_state = ST_IDLE;
      default:    next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    wb_cyc         = 1'b0;
    wb_stb         = 1'b0;
    wb_we          = 1'b0;
    current_client = CLI_NONE;
    vga_busy       = 1'b1;
    case (state)
      ST_ACTIVE: begin
        wb_cyc         = 1'b1;
        wb_stb         = 1'b1;
        wb_we          = lat_req.we;
        current_client = lat_cli;
        vga_busy       = !((lat_cli == CLI_VGA) && wb_ack);
      end
      ST_RELEASE: current_client = lat_cli;
      default: ;
    endcase
  end

  assign wb_adr    = lat_req.addr;
  assign wb_dat_o  = lat_req.wdata;
  assign wb_sel    = lat_req.sel;
  assign vga_rdata = wb_dat_i;

  // Grant latch and round-robin pointer update happen together at the IDLE edge.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      lat_req <= '0;
      lat_cli <= CLI_NONE;
      rr_ptr  <= RR_INIT;
    end else if (state == ST_IDLE && grant_vld) begin
      lat_req <= grant_req;
      lat_cli <= grant_cli;
      if (grant_cli == CLI_CPU)
        rr_ptr <= 1'b0;
      else if (grant_cli == CLI_UART)
        rr_ptr <= 1'b1;
    end
  end

  // Completion: acks land in RELEASE; a timeout forces read data to zero.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      cpu_ack    <= 1'b0;
      uart_ack   <= 1'b0;
      bus_err    <= 1'b0;
      cpu_rdata  <= '0;
      uart_rdata <= '0;
    end else begin
      cpu_ack  <= txn_end && (lat_cli == CLI_CPU);
      uart_ack <= txn_end && (lat_cli == CLI_UART);
      bus_err  <= txn_to;
      if (txn_end && lat_cli == CLI_CPU) begin
        if (txn_to)
          cpu_rdata <= '0;
        else if (!lat_req.we)
          cpu_rdata <= wb_dat_i;
      end
      if (txn_end && lat_cli == CLI_UART) begin
        if (txn_to)
          uart_rdata <= '0;
        else if (!lat_req.we)
          uart_rdata <= wb_dat_i;
      end
    end
  end

endmodule

// File: tb/tb_sram_client_arbiter.sv
// Scoreboard bench for sram_client_arbiter: client request queues, a latency-programmable
// Wishbone slave, and a monitor that pops expected completions in grant order.
module tb_sram_client_arbiter;
  import sram_arb_pkg::*;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        nrst;
  logic        cpu_req, cpu_we, uart_req, uart_we, vga_req;
  logic [31:0] cpu_addr, cpu_wdata, uart_addr, uart_wdata, vga_addr;
  logic [3:0]  cpu_sel, uart_sel, vga_sel;
  logic [1:0]  vga_state;
  logic [31:0] cpu_rdata, uart_rdata, vga_rdata;
  logic        cpu_ack, uart_ack, vga_busy;
  logic        wb_cyc, wb_stb, wb_we, wb_ack, bus_err;
  logic [31:0] wb_adr, wb_dat_o, wb_dat_i;
  logic [3:0]  wb_sel;
  logic [1:0]  current_client;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  sel;
  } cmd_t;

  typedef struct packed {
    logic [1:0]  cli;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  sel;
    logic [31:0] data;
    logic        err;
  } exp_t;

  cmd_t cpu_q[$], uart_q[$], vga_q[$];
  exp_t sb[$];
  int total = 0, bad = 0;
  int slv_lat = 1, scnt = 0;
  int run_len = 0, last_run = 0;
  logic [31:0] m_cpu_rd = '0, m_uart_rd = '0;

  always #5 clk = ~clk;

  sram_client_arbiter #(.TIMEOUT_CYCLES(TO), .RR_INIT(1'b0)) dut (
    .clk(clk), .nrst(nrst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_sel(cpu_sel), .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
    .uart_req(uart_req), .uart_we(uart_we), .uart_addr(uart_addr), .uart_wdata(uart_wdata),
    .uart_sel(uart_sel), .uart_rdata(uart_rdata), .uart_ack(uart_ack),
    .vga_req(vga_req), .vga_addr(vga_addr), .vga_sel(vga_sel), .vga_state(vga_state),
    .vga_rdata(vga_rdata), .vga_busy(vga_busy),
    .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we), .wb_adr(wb_adr), .wb_dat_o(wb_dat_o),
    .wb_sel(wb_sel), .wb_dat_i(wb_dat_i), .wb_ack(wb_ack),
    .current_client(current_client), .bus_err(bus_err)
  );

  function automatic logic [31:0] slave_data(input logic [31:0] a);
    case (a)
      32'h10:  return 32'hDEAD_BEEF;
      32'h04:  return 32'h0000_FFFF;
      default: return a ^ 32'h5A5A_0000;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic send(input logic [1:0] cli, input logic we, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [3:0] sel);
    cmd_t c;
    c = '{we: we, addr: addr, wdata: wdata, sel: sel};
    case (cli)
      2'd0:    cpu_q.push_back(c);
      2'd1:    vga_q.push_back(c);
      default: uart_q.push_back(c);
    endcase
  endtask

  // Expectations are pushed in the order completions must appear.
  task automatic expect_txn(input logic [1:0] cli, input logic we, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [3:0] sel, input logic err);
    exp_t e;
    logic [31:0] d;
    if (cli == 2'd1) d = slave_data(addr);
    else if (err) d = 32'd0;
    else if (we) d = (cli == 2'd0) ? m_cpu_rd : m_uart_rd;
    else d = slave_data(addr);
    if (cli == 2'd0) m_cpu_rd = d;
    if (cli == 2'd2) m_uart_rd = d;
    e = '{cli: cli, we: we, addr: addr, wdata: wdata, sel: sel, data: d, err: err};
    sb.push_back(e);
  endtask

  task automatic wait_sb(input int max);
    int n = 0;
    while (sb.size() != 0 && n < max) begin
      @(negedge clk);
      n++;
    end
    if (n >= max) chk("sb_wait", 32'(sb.size()), 32'd0);
  endtask

  task automatic wait_done(input int max);
    int n = 0;
    while ((sb.size() + cpu_q.size() + uart_q.size() + vga_q.size()) != 0 && n < max) begin
      @(negedge clk);
      n++;
    end
    if (n >= max) chk("done_wait", 32'(sb.size() + cpu_q.size() + uart_q.size() + vga_q.size()), 32'd0);
  endtask

  task automatic wait_grant(input logic [1:0] cli, input int max);
    int n = 0;
    while (!(wb_cyc && current_client == cli) && n < max) begin
      @(negedge clk);
      n++;
    end
    if (n >= max) chk("grant_wait", 32'(wb_cyc && current_client == cli), 32'd1);
  endtask

  // Wishbone slave: acks slv_lat cycles after stb rises (negative = never).
  initial begin
    wb_ack = 1'b0;
    wb_dat_i = '0;
    forever begin
      @(negedge clk);
      if (wb_cyc && wb_stb) begin
        if (scnt == slv_lat) begin
          wb_ack = 1'b1;
          wb_dat_i = slave_data(wb_adr);
        end else begin
          wb_ack = 1'b0;
          wb_dat_i = 32'h0BAD_F00D;
        end
        scnt++;
      end else begin
        scnt = 0;
        wb_ack = 1'b0;
      end
    end
  end

  // Monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (wb_cyc) run_len++;
      else if (run_len > 0) begin
        last_run = run_len;
        run_len = 0;
      end
      if (wb_cyc && wb_ack) begin
        if (sb.size() == 0) chk("ack_unexpected", 32'(sb.size()), 32'd1);
        else begin
          e = sb[0];
          chk("wb_adr", wb_adr, e.addr);
          chk("wb_we", 32'(wb_we), 32'(e.we));
          chk("wb_sel", 32'(wb_sel), 32'(e.sel));
          if (e.we) chk("wb_dat_o", wb_dat_o, e.wdata);
          chk("cli_active", 32'(current_client), 32'(e.cli));
        end
      end
      if (!vga_busy) begin
        if (sb.size() == 0) chk("vga_unexpected", 32'(sb.size()), 32'd1);
        else begin
          e = sb.pop_front();
          chk("vga_cli", 32'(e.cli), 32'(CLI_VGA));
          chk("vga_rdata", vga_rdata, e.data);
        end
      end
      if (cpu_ack || uart_ack) begin
        if (sb.size() == 0) chk("ack_extra", 32'(sb.size()), 32'd1);
        else begin
          e = sb.pop_front();
          chk("ack_cli", cpu_ack ? 32'd0 : 32'd2, 32'(e.cli));
          chk("rdata", cpu_ack ? cpu_rdata : uart_rdata, e.data);
          chk("bus_err", 32'(bus_err), 32'(e.err));
          chk("release_cyc", 32'(wb_cyc), 32'd0);
          chk("cli_release", 32'(current_client), 32'(e.cli));
        end
      end
      if (bus_err && !(cpu_ack || uart_ack)) chk("err_alone", 32'(bus_err), 32'd0);
    end
  end

  // Client driver: each request stays up while its queue has work.
  initial begin
    cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0; cpu_sel = 0;
    uart_req = 0; uart_we = 0; uart_addr = 0; uart_wdata = 0; uart_sel = 0;
    vga_req = 0; vga_addr = 0; vga_sel = 0;
    forever begin
      @(negedge clk);
      #2;
      if (cpu_ack && cpu_q.size() > 0) void'(cpu_q.pop_front());
      if (uart_ack && uart_q.size() > 0) void'(uart_q.pop_front());
      if (!vga_busy && vga_q.size() > 0) void'(vga_q.pop_front());
      cpu_req = (cpu_q.size() > 0);
      if (cpu_req) {cpu_we, cpu_addr, cpu_wdata, cpu_sel} = cpu_q[0];
      uart_req = (uart_q.size() > 0);
      if (uart_req) {uart_we, uart_addr, uart_wdata, uart_sel} = uart_q[0];
      vga_req = (vga_q.size() > 0);
      if (vga_req) begin
        vga_addr = vga_q[0].addr;
        vga_sel = vga_q[0].sel;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    nrst = 1'b0;
    vga_state = 2'd0;
    repeat (3) @(negedge clk);
    chk("rst_cyc", 32'(wb_cyc), 32'd0);
    chk("rst_stb", 32'(wb_stb), 32'd0);
    chk("rst_we", 32'(wb_we), 32'd0);
    chk("rst_adr", wb_adr, 32'd0);
    chk("rst_dat_o", wb_dat_o, 32'd0);
    chk("rst_sel", 32'(wb_sel), 32'd0);
    chk("rst_acks", 32'({cpu_ack, uart_ack}), 32'd0);
    chk("rst_bus_err", 32'(bus_err), 32'd0);
    chk("rst_vga_busy", 32'(vga_busy), 32'd1);
    chk("rst_cpu_rdata", cpu_rdata, 32'd0);
    chk("rst_uart_rdata", uart_rdata, 32'd0);
    chk("rst_client", 32'(current_client), 32'd3);
    nrst = 1'b1;

    // Round-robin under simultaneous CPU/UART requests: UART wins first.
    slv_lat = 1;
    send(2'd0, 1'b0, 32'h100, 32'd0, 4'hF);
    send(2'd0, 1'b0, 32'h104, 32'd0, 4'hF);
    send(2'd2, 1'b0, 32'h200, 32'd0, 4'h1);
    send(2'd2, 1'b0, 32'h204, 32'd0, 4'h1);
    expect_txn(2'd2, 1'b0, 32'h200, 32'd0, 4'h1, 1'b0);
    expect_txn(2'd0, 1'b0, 32'h100, 32'd0, 4'hF, 1'b0);
    expect_txn(2'd2, 1'b0, 32'h204, 32'd0, 4'h1, 1'b0);
    expect_txn(2'd0, 1'b0, 32'h104, 32'd0, 4'hF, 1'b0);
    wait_done(200);

    // CPU read with the slave acking two cycles after stb.
    slv_lat = 2;
    send(2'd0, 1'b0, 32'h10, 32'd0, 4'hF);
    expect_txn(2'd0, 1'b0, 32'h10, 32'd0, 4'hF, 1'b0);
    wait_done(100);
    repeat (3) @(negedge clk);
    chk("cpu_rdata_hold", cpu_rdata, 32'hDEAD_BEEF);

    // VGA read acked in the same cycle as stb.
    slv_lat = 0;
    send(2'd1, 1'b0, 32'h04, 32'd0, 4'hF);
    expect_txn(2'd1, 1'b0, 32'h04, 32'd0, 4'hF, 1'b0);
    wait_done(100);
    chk("vga_busy_idle", 32'(vga_busy), 32'd1);

    // vga_state goes non-inactive while a UART write is on the bus.
    slv_lat = 3;
    send(2'd2, 1'b1, 32'h300, 32'h1234_5678, 4'h3);
    expect_txn(2'd2, 1'b1, 32'h300, 32'h1234_5678, 4'h3, 1'b0);
    wait_grant(2'd2, 50);
    vga_state = 2'd1;
    send(2'd0, 1'b0, 32'h400, 32'd0, 4'hF);
    wait_sb(100);
    repeat (4) @(negedge clk);
    chk("cpu_blocked_cli", 32'(current_client), 32'd3);
    chk("cpu_blocked_q", 32'(cpu_q.size()), 32'd1);
    slv_lat = 1;
    send(2'd1, 1'b0, 32'h08, 32'd0, 4'hF);
    expect_txn(2'd1, 1'b0, 32'h08, 32'd0, 4'hF, 1'b0);
    wait_sb(100);
    chk("cpu_still_blocked", 32'(cpu_q.size()), 32'd1);
    expect_txn(2'd0, 1'b0, 32'h400, 32'd0, 4'hF, 1'b0);
    vga_state = 2'd0;
    wait_done(100);

    // Slave never acks: abort after TO active cycles.
    slv_lat = -1;
    send(2'd0, 1'b0, 32'h500, 32'd0, 4'hF);
    expect_txn(2'd0, 1'b0, 32'h500, 32'd0, 4'hF, 1'b1);
    wait_done(100);
    chk("timeout_len", 32'(last_run), 32'(TO));
    chk("timeout_rdata", cpu_rdata, 32'd0);

    // Reset in the middle of ACTIVE, then the pending request is served again.
    slv_lat = 5;
    send(2'd0, 1'b0, 32'h600, 32'd0, 4'hF);
    expect_txn(2'd0, 1'b0, 32'h600, 32'd0, 4'hF, 1'b0);
    wait_grant(2'd0, 50);
    @(negedge clk);
    #3 nrst = 1'b0;
    #1;
    chk("midrst_cyc", 32'(wb_cyc), 32'd0);
    chk("midrst_stb", 32'(wb_stb), 32'd0);
    chk("midrst_cli", 32'(current_client), 32'd3);
    chk("midrst_ack", 32'(cpu_ack), 32'd0);
    @(negedge clk);
    chk("midrst_ack2", 32'(cpu_ack), 32'd0);
    #4 nrst = 1'b1;
    wait_done(100);

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
